regfile_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the CPU's 4×8-bit register file. It shares the file's single write/read port pair between requester A (execute/writeback) and requester B (load/debug), one transaction per granted cycle. Arbitration is round-robin, with bounded locked bursts. Read results are registered and returned one cycle after the grant. The block sits between the control unit and the register file and is the only driver of the file's address, data and write-enable inputs.

---
 rtl/regfile_arbiter.sv | 149 ++++++++++++++
 tb/tb_regfile_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter and sequencer sharing a 4x8 register file between two requesters,
// with bounded locked bursts and registered read return one cycle after each grant.
module regfile_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       lock_a,
    input  logic       lock_b,
    input  logic       we_a,
    input  logic       we_b,
    input  logic [1:0] addr1_a,
    input  logic [1:0] addr1_b,
    input  logic [1:0] addr2_a,
    input  logic [1:0] addr2_b,
    input  logic [7:0] wdata_a,
    input  logic [7:0] wdata_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       rvalid_a,
    output logic       rvalid_b,
    output logic [7:0] rdata1,
    output logic [7:0] rdata2,
    output logic       rf_wen,
    output logic [1:0] rf_in_1,
    output logic [1:0] rf_in_2,
    output logic [7:0] rf_data,
    input  logic [7:0] rf_out_1,
    input  logic [7:0] rf_out_2
);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;
    typedef enum logic {REQ_A, REQ_B} req_id_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST - 1);

    state_t     state_q, state_d;
    req_id_t    last_q, last_d;
    logic [3:0] burst_q, burst_d;
    logic       rvalid_a_q, rvalid_a_d;
    logic       rvalid_b_q, rvalid_b_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic [7:0] rdata2_q, rdata2_d;
    logic       tx_a, tx_b;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= REQ_B;
            burst_q    <= 4'd0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata1_q   <= 8'h00;
            rdata2_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        burst_d    = 4'd0;
        last_d     = last_q;
        rvalid_a_d = tx_a;
        rvalid_b_d = tx_b;
        rdata1_d   = rdata1_q;
        rdata2_d   = rdata2_q;

        if (tx_a) begin
            last_d = REQ_A;
        end else if (tx_b) begin
            last_d = REQ_B;
        end

        // Read ports are sampled at the grant edge, so a write returns the old contents.
        if (tx_a || tx_b) begin
            rdata1_d = rf_out_1;
            rdata2_d = rf_out_2;
        end

        if (!req_a && !req_b) begin
            state_d = IDLE;
        end else if (req_a && !req_b) begin
            state_d = GNT_A;
        end else if (!req_a && req_b) begin
            state_d = GNT_B;
        end else begin
            unique case (state_q)
                IDLE:  state_d = (last_q == REQ_B) ? GNT_A : GNT_B;
                GNT_A: begin
                    if (lock_a && (burst_q < BURST_LIMIT)) begin
                        burst_d = burst_q + 4'd1;
                    end else begin
                        state_d = GNT_B;
                    end
                end
                GNT_B: begin
                    if (lock_b && (burst_q < BURST_LIMIT)) begin
                        burst_d = burst_q + 4'd1;
                    end else begin
                        state_d = GNT_A;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        // NOTE: reset gates the grant combinationally so no write lands on the reset edge.
        tx_a    = !rst && (state_q == GNT_A) && req_a;
        tx_b    = !rst && (state_q == GNT_B) && req_b;
        gnt_a   = tx_a;
        gnt_b   = tx_b;
        rf_wen  = 1'b0;
        rf_in_1 = 2'd0;
        rf_in_2 = 2'd0;
        rf_data = 8'h00;
        if (tx_a) begin
            rf_wen  = we_a;
            rf_in_1 = addr1_a;
            rf_in_2 = addr2_a;
            rf_data = wdata_a;
        end else if (tx_b) begin
            rf_wen  = we_b;
            rf_in_1 = addr1_b;
            rf_in_2 = addr2_b;
            rf_data = wdata_b;
        end
    end

    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata1   = rdata1_q;
    assign rdata2   = rdata2_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed scenarios pinned by literals, then
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_regfile_arbiter;

    localparam int MAX_BURST = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b, lock_a, lock_b, we_a, we_b;
    logic [1:0] addr1_a, addr1_b, addr2_a, addr2_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b, rf_wen;
    logic [7:0] rdata1, rdata2, rf_data, rf_out_1, rf_out_2;
    logic [1:0] rf_in_1, rf_in_2;

    always #5 clk = ~clk;

    regfile_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .lock_a(lock_a), .lock_b(lock_b),
        .we_a(we_a), .we_b(we_b),
        .addr1_a(addr1_a), .addr1_b(addr1_b), .addr2_a(addr2_a), .addr2_b(addr2_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata1(rdata1), .rdata2(rdata2),
        .rf_wen(rf_wen), .rf_in_1(rf_in_1), .rf_in_2(rf_in_2), .rf_data(rf_data),
        .rf_out_1(rf_out_1), .rf_out_2(rf_out_2)
    );

    // Register file the arbiter drives: synchronous write, combinational read.
    logic [7:0] rf_mem [4] = '{default: 8'h00};
    always @(posedge clk) if (rf_wen) rf_mem[rf_in_1] <= rf_data;
    assign rf_out_1 = rf_mem[rf_in_1];
    assign rf_out_2 = rf_mem[rf_in_2];

    // Reference model: owner 0 = nobody, 1 = A, 2 = B.
    int         m_owner, m_last, m_burst;
    logic [7:0] m_mem [4];
    logic [7:0] exp_rdata1, exp_rdata2;
    logic       exp_rvalid_a, exp_rvalid_b, exp_tx_a, exp_tx_b;

    logic       obs_gnt_a, obs_gnt_b, obs_rvalid_a, obs_rvalid_b, obs_rf_wen;
    logic [7:0] obs_rdata1, obs_rdata2, obs_rf_data;
    logic [1:0] obs_rf_in_1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [1:0] a1, a2;
        int both, nxt, lk;
        if (rst) begin
            m_owner = 0; m_last = 2; m_burst = 0;
            exp_rvalid_a = 1'b0; exp_rvalid_b = 1'b0;
            exp_rdata1 = 8'h00; exp_rdata2 = 8'h00;
            return;
        end
        if (exp_tx_a || exp_tx_b) begin
            a1 = exp_tx_a ? addr1_a : addr1_b;
            a2 = exp_tx_a ? addr2_a : addr2_b;
            exp_rdata1 = m_mem[a1];
            exp_rdata2 = m_mem[a2];
            if (exp_tx_a ? we_a : we_b) m_mem[a1] = exp_tx_a ? wdata_a : wdata_b;
        end
        exp_rvalid_a = exp_tx_a;
        exp_rvalid_b = exp_tx_b;
        both = (req_a && req_b) ? 1 : 0;
        if (!req_a && !req_b)      nxt = 0;
        else if (!both)            nxt = req_a ? 1 : 2;
        else if (m_owner == 0)     nxt = (m_last == 1) ? 2 : 1;
        else begin
            lk  = (m_owner == 1) ? int'(lock_a) : int'(lock_b);
            nxt = (lk == 1 && m_burst < MAX_BURST - 1) ? m_owner : 3 - m_owner;
        end
        m_burst = (both == 1 && nxt != 0 && nxt == m_owner) ? m_burst + 1 : 0;
        m_owner = nxt;
        if (exp_tx_a) m_last = 1;
        if (exp_tx_b) m_last = 2;
    endtask

    // One clock cycle: compare away from the edge, then advance the model at the edge.
    task automatic tick();
        logic       e_wen;
        #1;
        exp_tx_a = !rst && m_owner == 1 && req_a;
        exp_tx_b = !rst && m_owner == 2 && req_b;
        e_wen    = exp_tx_a ? we_a : (exp_tx_b ? we_b : 1'b0);
        obs_gnt_a = gnt_a; obs_gnt_b = gnt_b; obs_rvalid_a = rvalid_a; obs_rvalid_b = rvalid_b;
        obs_rdata1 = rdata1; obs_rdata2 = rdata2; obs_rf_wen = rf_wen;
        obs_rf_in_1 = rf_in_1; obs_rf_data = rf_data;
        check("gnt_a", gnt_a, exp_tx_a);
        check("gnt_b", gnt_b, exp_tx_b);
        check("rvalid_a", rvalid_a, exp_rvalid_a);
        check("rvalid_b", rvalid_b, exp_rvalid_b);
        check("rdata1", rdata1, exp_rdata1);
        check("rdata2", rdata2, exp_rdata2);
        check("rf_wen", rf_wen, e_wen);
        if (exp_tx_a || exp_tx_b) begin
            check("rf_in_1", rf_in_1, exp_tx_a ? addr1_a : addr1_b);
            check("rf_in_2", rf_in_2, exp_tx_a ? addr2_a : addr2_b);
            check("rf_data", rf_data, exp_tx_a ? wdata_a : wdata_b);
        end else if (m_owner == 0) begin
            check("idle_rf_in_1", rf_in_1, 0);
            check("idle_rf_in_2", rf_in_2, 0);
            check("idle_rf_data", rf_data, 0);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        logic [10:0] pat_a, pat_b;
        logic        new_a, new_b;
        for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
        m_owner = 0; m_last = 2; m_burst = 0;
        exp_rdata1 = 8'h00; exp_rdata2 = 8'h00;
        exp_rvalid_a = 1'b0; exp_rvalid_b = 1'b0; exp_tx_a = 1'b0; exp_tx_b = 1'b0;
        rst = 1'b1; req_a = 0; req_b = 0; lock_a = 0; lock_b = 0; we_a = 0; we_b = 0;
        addr1_a = 0; addr1_b = 0; addr2_a = 0; addr2_b = 0; wdata_a = 0; wdata_b = 0;
        @(negedge clk);
        tick(); tick();

        // Write 0x5A to r2 from A, then read it back through B.
        rst = 1'b0; req_a = 1; we_a = 1; addr1_a = 2; wdata_a = 8'h5A;
        tick();
        check("c1_gnt_a_low", obs_gnt_a, 0);
        check("c1_rdata1_reset", obs_rdata1, 0);
        tick();
        check("c2_gnt_a", obs_gnt_a, 1);
        check("c2_rf_wen", obs_rf_wen, 1);
        check("c2_rf_in_1", obs_rf_in_1, 2);
        check("c2_rf_data", obs_rf_data, 8'h5A);
        req_a = 0; we_a = 0; req_b = 1; we_b = 0; addr1_b = 2; addr2_b = 2;
        tick();
        check("c3_rvalid_a", obs_rvalid_a, 1);
        check("c3_gnt_b_low", obs_gnt_b, 0);
        tick();
        check("c4_gnt_b", obs_gnt_b, 1);
        req_b = 0;
        tick();
        check("c5_rvalid_b", obs_rvalid_b, 1);
        check("c5_rdata1", obs_rdata1, 8'h5A);
        check("c5_rdata2", obs_rdata2, 8'h5A);
        tick(); tick();

        // Locked burst from A against a continuously requesting B.
        req_a = 1; req_b = 1; lock_a = 1; lock_b = 0;
        addr1_a = 0; addr2_a = 1; addr1_b = 3; addr2_b = 2;
        pat_a = '0; pat_b = '0;
        for (int i = 0; i < 11; i++) begin
            tick();
            pat_a = {pat_a[9:0], obs_gnt_a};
            pat_b = {pat_b[9:0], obs_gnt_b};
        end
        check("burst_pattern_a", pat_a, 11'b01111011110);
        check("burst_pattern_b", pat_b, 11'b00000100001);
        req_a = 0; req_b = 0; lock_a = 0;
        tick(); tick();

        // Read-after-write across requesters, no bypass needed.
        req_a = 1;
        tick();
        we_a = 1; addr1_a = 1; wdata_a = 8'h33; req_b = 1; addr1_b = 1; addr2_b = 0; we_b = 0;
        tick();
        check("raw_gnt_a", obs_gnt_a, 1);
        req_a = 0; we_a = 0;
        tick();
        check("raw_gnt_b", obs_gnt_b, 1);
        req_b = 0;
        tick();
        check("raw_rvalid_b", obs_rvalid_b, 1);
        check("raw_rdata1", obs_rdata1, 8'h33);
        tick();

        // Reset landing on a B write grant.
        req_b = 1;
        tick();
        rst = 1; we_b = 1; addr1_b = 3; wdata_b = 8'hEE;
        tick();
        check("rst_rf_wen", obs_rf_wen, 0);
        check("rst_gnt_b", obs_gnt_b, 0);
        rst = 0; req_a = 1; we_a = 0; addr1_a = 3; addr2_a = 3;
        tick();
        check("post_rst_gnt_a", obs_gnt_a, 0);
        check("post_rst_rvalid_b", obs_rvalid_b, 0);
        check("post_rst_rdata1", obs_rdata1, 0);
        tick();
        check("post_rst_tie_gnt_a", obs_gnt_a, 1);
        check("post_rst_tie_gnt_b", obs_gnt_b, 0);
        tick();
        check("post_rst_rvalid_a", obs_rvalid_a, 1);
        check("no_write_at_reset", obs_rdata1, 8'h00);
        req_a = 0; req_b = 0; we_b = 0;
        tick();

        // Randomized traffic; a requester holds its fields until granted.
        for (int n = 0; n < 4000; n++) begin
            new_a = !req_a || exp_tx_a;
            new_b = !req_b || exp_tx_b;
            rst = ($urandom_range(0, 299) == 0);
            if (new_a) begin
                req_a = ($urandom_range(0, 3) != 0); lock_a = $urandom_range(0, 1);
                we_a = $urandom_range(0, 1); wdata_a = 8'($urandom);
                addr1_a = 2'($urandom); addr2_a = 2'($urandom);
            end
            if (new_b) begin
                req_b = ($urandom_range(0, 3) != 0); lock_b = $urandom_range(0, 1);
                we_b = $urandom_range(0, 1); wdata_b = 8'($urandom);
                addr1_b = 2'($urandom); addr2_b = 2'($urandom);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
